// File: rtl/uart_pkg.sv
// UART shared definitions: receiver FSM state encoding and frame data width.
// Intended to be shared by the receiver and a future transmitter.
package uart_pkg;
  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset (empties FIFO, zeroes storage)
//   push, din   write request and data; accepted when not full, or when full with a pop
//   pop         read request; ignored while empty
//   dout        head entry (valid when !empty)
//   empty/full  status; count = occupancy 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push, w_do_pop;

  assign empty = (r_count == '0);
  assign full  = (r_count == FULL_CNT);
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  // A full FIFO can still take a write when the head leaves in the same
  // cycle: the slot being written is the one the head vacates.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with receive FIFO, sticky error flags and level interrupt.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   rx           asynchronous serial input, idle high
//   rd_en        pop strobe; rd_data is the FIFO head (first-word-fall-through)
//   rx_empty, rx_full, fifo_count   FIFO status
//   frame_err    sticky: stop bit sampled low
//   overrun      sticky: byte completed while FIFO full and not popped that cycle
//   clr_err      clears both sticky flags
//   irq          level: data available or any error flag set
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 347,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rx_empty,
  output logic                          rx_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          clr_err,
  output logic                          irq
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int NW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [NW-1:0] BIT_LAST  = NW'(DATA_BITS - 1);

  rx_state_t            r_state, w_state_next;
  logic                 r_rx_meta, r_rx_sync, r_rx_prev;
  logic [BW-1:0]        r_baud;
  logic [NW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_frame_err, r_overrun;
  logic                 w_baud_last, w_baud_half;
  logic                 w_push, w_frame_evt, w_overrun_evt;
  logic                 w_empty, w_full;

  assign w_baud_last = (r_baud == BAUD_LAST);
  assign w_baud_half = (r_baud == BAUD_HALF);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next state and per-cycle events
  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_frame_evt  = 1'b0;
    case (r_state)
      // Only a falling edge starts a frame, so a line stuck low after a
      // framing error does not retrigger.
      IDLE:  if (r_rx_prev & ~r_rx_sync) w_state_next = START;
      START: if (w_baud_half) w_state_next = r_rx_sync ? IDLE : DATA;
      DATA:  if (w_baud_last && r_bit == BIT_LAST) w_state_next = STOP;
      STOP: begin
        if (w_baud_last) begin
          w_state_next = IDLE;
          w_push       = r_rx_sync;
          w_frame_evt  = ~r_rx_sync;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Full FIFO is never empty, so a pending rd_en always frees a slot.
  assign w_overrun_evt = w_push & w_full & ~rd_en;

  // Synchroniser, baud/bit counters, shift register, sticky flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_meta   <= 1'b1;
      r_rx_sync   <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_baud      <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;

      // Counter restarts on every state change and at each data bit boundary.
      if (r_state != w_state_next || (r_state == DATA && w_baud_last))
        r_baud <= '0;
      else if (r_state != IDLE)
        r_baud <= r_baud + 1'b1;

      if (r_state == START) begin
        r_bit <= '0;
      end else if (r_state == DATA && w_baud_last) begin
        r_shift <= {r_rx_sync, r_shift[DATA_BITS-1:1]};
        r_bit   <= r_bit + 1'b1;
      end

      // Set after clear so a coincident error event keeps the flag high.
      if (clr_err)       r_frame_err <= 1'b0;
      if (w_frame_evt)   r_frame_err <= 1'b1;
      if (clr_err)       r_overrun   <= 1'b0;
      if (w_overrun_evt) r_overrun   <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .din   (r_shift),
    .pop   (rd_en),
    .dout  (rd_data),
    .empty (w_empty),
    .full  (w_full),
    .count (fifo_count)
  );

  assign rx_empty  = w_empty;
  assign rx_full   = w_full;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign irq       = ~w_empty | r_frame_err | r_overrun;
endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0, rst_n = 1'b0, rx = 1'b1, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] rd_data;
  logic       rx_empty, rx_full, frame_err, overrun, irq;
  logic [2:0] fifo_count;

  int n_tests = 0, n_fail = 0;
  int push_lat = -1;

  // Reference model: byte queue plus sticky flags, updated per whole frame.
  logic [7:0] mq[$];
  bit         m_fe, m_ov;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rd_en(rd_en), .rd_data(rd_data),
    .rx_empty(rx_empty), .rx_full(rx_full), .fifo_count(fifo_count),
    .frame_err(frame_err), .overrun(overrun), .clr_err(clr_err), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    chk({tag, ".empty"}, 32'(rx_empty),   32'(mq.size() == 0));
    chk({tag, ".full"},  32'(rx_full),    32'(mq.size() == DEPTH));
    chk({tag, ".count"}, 32'(fifo_count), 32'(mq.size()));
    chk({tag, ".ferr"},  32'(frame_err),  32'(m_fe));
    chk({tag, ".ovr"},   32'(overrun),    32'(m_ov));
    chk({tag, ".irq"},   32'(irq),        32'((mq.size() != 0) | m_fe | m_ov));
    if (mq.size() != 0) chk({tag, ".data"}, 32'(rd_data), 32'(mq[0]));
  endtask

  // Drives one 8N1 frame; must be called just after a rising edge.
  task automatic send_frame(input logic [7:0] b, input bit stop);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = stop;
    repeat (CPB) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit stop);
    if (!stop) m_fe = 1'b1;
    else if (mq.size() < DEPTH) mq.push_back(b);
    else m_ov = 1'b1;
  endtask

  task automatic frame(input logic [7:0] b, input bit stop);
    @(posedge clk);
    #1;
    send_frame(b, stop);
    model_frame(b, stop);
    check_state("frame");
  endtask

  task automatic pop();
    @(posedge clk);
    #1 rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
    check_state("pop");
  endtask

  task automatic clr();
    @(posedge clk);
    #1 clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    m_fe = 1'b0;
    m_ov = 1'b0;
    check_state("clr");
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mq.delete(); m_fe = 0; m_ov = 0;
    check_state("reset");
    chk("reset.data", 32'(rd_data), 32'h0);

    // Single frame 0xA5: measure cycles from start bit to data availability
    @(posedge clk);
    #1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int n = 0; n < 200; n++) begin
          @(negedge clk);
          if (!rx_empty) begin
            push_lat = n;
            chk("a5.irq_at_push", 32'(irq), 32'h1);
            chk("a5.data_at_push", 32'(rd_data), 32'hA5);
            break;
          end
        end
      end
    join
    // Stop-bit centre is 9.5 bits after the start edge, plus sync/edge delay.
    chk("a5.latency_window", 32'(push_lat >= 152 && push_lat <= 157), 32'h1);
    model_frame(8'hA5, 1'b1);
    check_state("a5");
    pop();

    // 0x01..0x05 without pops: fills, fifth overruns
    for (int i = 1; i <= 5; i++) frame(8'(i), 1'b1);
    for (int i = 0; i < 4; i++) pop();
    clr();

    // Framing error
    frame(8'h3C, 1'b0);
    clr();

    // Short low glitch: nothing captured, receiver still usable afterwards
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (5) @(posedge clk);
    #1 rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    check_state("glitch");
    frame(8'h5A, 1'b1);
    pop();

    // Pop while empty is ignored
    pop();

    // Full FIFO with a pop in the stop-sample cycle of 0x77
    for (int i = 0; i < DEPTH; i++) frame(8'($urandom), 1'b1);
    @(posedge clk);
    #1;
    fork
      send_frame(8'h77, 1'b1);
      begin
        if (push_lat > 1) begin
          repeat (push_lat - 1) @(posedge clk);
          #1 rd_en = 1'b1;
          @(posedge clk);
          #1 rd_en = 1'b0;
        end
      end
    join
    void'(mq.pop_front());
    mq.push_back(8'h77);
    check_state("pushpop_full");
    for (int i = 0; i < DEPTH; i++) pop();

    // Reset during data bit 3, with stale data and a flag present
    frame(8'h99, 1'b1);
    frame(8'h42, 1'b0);
    @(posedge clk);
    #1;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (CPB * 4 + CPB / 2) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
      end
    join
    mq.delete(); m_fe = 0; m_ov = 0;
    check_state("midreset");
    chk("midreset.data", 32'(rd_data), 32'h0);
    frame(8'h12, 1'b1);
    pop();

    // Randomized frames, stop errors, pops and clears
    for (int r = 0; r < 14; r++) begin
      frame(8'($urandom), $urandom_range(0, 7) != 0);
      repeat ($urandom_range(0, 2)) pop();
      if ($urandom_range(0, 3) == 0) clr();
    end
    while (mq.size() != 0) pop();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
